// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Receive-side checker for a VGA timing stream. Registers hsync/vsync/de,
//   measures line length (clocks between hsync leading edges) and frame length
//   (hsync edges between vsync leading edges), recovers pixel coordinates and
//   declares lock once LOCK_FRAMES consecutive frames match the configured mode.
// Ports
//   clk           pixel clock
//   reset         synchronous, active-high reset
//   hsync, vsync  sync inputs, active level set by SYNC_POL
//   de            display enable
//   pix_valid     registered de (1 clock latency)
//   pix_x, pix_y  recovered column / row, aligned with pix_valid
//   h_total_meas  last measured line length in clocks
//   v_total_meas  last measured frame length in lines
//   locked        timing matches parameters
//   sync_err      one-cycle pulse on a timing mismatch (never while searching)
module vga_sync_decoder #(
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        de,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [10:0] h_total_meas,
  output logic [10:0] v_total_meas,
  output logic        locked,
  output logic        sync_err
);

  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [10:0] H_ACT_C = 11'(H_ACTIVE);
  localparam logic [10:0] H_TOT_C = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT_C = 11'(V_TOTAL);
  localparam logic [7:0]  LOCK_C  = 8'(LOCK_FRAMES);

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  logic        hs_p0_q, hs_p0_d, hs_p1_q, hs_p1_d;
  logic        vs_p0_q, vs_p0_d, vs_p1_q, vs_p1_d;
  logic        de_p0_q, de_p0_d, de_p1_q, de_p1_d;
  logic [10:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, de_cnt_q, de_cnt_d;
  logic        h_started_q, h_started_d;
  logic [10:0] h_meas_q, h_meas_d, v_meas_q, v_meas_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic        row_first_q, row_first_d;
  state_t      state_q, state_d;
  logic [7:0]  good_q, good_d;
  logic        frame_ok_q, frame_ok_d;
  logic        locked_q, locked_d, sync_err_q, sync_err_d;

  logic        hs_lead, vs_lead, de_fall, de_rise_in;
  logic        line_bad, frame_len_bad, run_bad;
  logic [7:0]  good_inc;

  // Stage p0/p1: polarity-normalised input registers and edge detect
  assign hs_lead    = hs_p0_q & ~hs_p1_q;
  assign vs_lead    = vs_p0_q & ~vs_p1_q;
  assign de_fall    = de_p1_q & ~de_p0_q;
  // Compared against the input so the row update lands with pix_valid.
  assign de_rise_in = de & ~de_p0_q;

  assign line_bad      = hs_lead & h_started_q & (h_cnt_q != H_TOT_C);
  assign frame_len_bad = (v_cnt_q != V_TOT_C);
  assign run_bad       = de_fall & (de_cnt_q != H_ACT_C);
  assign good_inc      = good_q + 8'd1;

  always_comb begin
    hs_p0_d = (hsync == SYNC_POL);
    vs_p0_d = (vsync == SYNC_POL);
    de_p0_d = de;
    hs_p1_d = hs_p0_q;
    vs_p1_d = vs_p0_q;
    de_p1_d = de_p0_q;

    // Line length: the first edge only arms the counter.
    h_cnt_d     = h_cnt_q;
    h_started_d = h_started_q;
    h_meas_d    = h_meas_q;
    if (hs_lead) begin
      if (h_started_q) h_meas_d = h_cnt_q;
      h_cnt_d     = 11'd1;
      h_started_d = 1'b1;
    end else if (h_started_q) begin
      h_cnt_d = sat_inc11(h_cnt_q);
    end

    // Frame length: an hsync edge coinciding with vsync belongs to the new frame.
    v_cnt_d  = v_cnt_q;
    v_meas_d = v_meas_q;
    if (vs_lead) begin
      v_meas_d = v_cnt_q;
      v_cnt_d  = hs_lead ? 11'd1 : 11'd0;
    end else if (hs_lead) begin
      v_cnt_d = sat_inc11(v_cnt_q);
    end

    // Active run length, valid at de fall
    de_cnt_d = de_cnt_q;
    if (de_p0_q) de_cnt_d = de_p1_q ? sat_inc11(de_cnt_q) : 11'd1;

    pix_x_d = pix_x_q;
    if (de) pix_x_d = de_p0_q ? sat_inc10(pix_x_q) : 10'd0;

    // After vsync the first de rise keeps the cleared row (0) instead of incrementing.
    pix_y_d     = pix_y_q;
    row_first_d = row_first_q;
    if (vs_lead) begin
      pix_y_d     = 10'd0;
      row_first_d = 1'b1;
    end else if (de_rise_in) begin
      pix_y_d     = row_first_q ? pix_y_q : sat_inc10(pix_y_q);
      row_first_d = 1'b0;
    end
  end

  // Stage p2: lock FSM
  always_comb begin
    state_d    = state_q;
    good_d     = good_q;
    frame_ok_d = frame_ok_q;
    sync_err_d = 1'b0;
    case (state_q)
      SEARCH: begin
        if (vs_lead) begin
          state_d    = MEASURE;
          good_d     = 8'd0;
          frame_ok_d = 1'b1;
        end
      end
      MEASURE: begin
        if (line_bad) begin
          frame_ok_d = 1'b0;
          sync_err_d = 1'b1;
        end
        if (vs_lead) begin
          frame_ok_d = 1'b1;
          if (frame_ok_q && !line_bad && !frame_len_bad) begin
            good_d = good_inc;
            if (good_inc >= LOCK_C) state_d = LOCKED;
          end else begin
            good_d = 8'd0;
            if (frame_len_bad) sync_err_d = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (line_bad || (vs_lead && frame_len_bad) || run_bad) begin
          state_d    = MEASURE;
          good_d     = 8'd0;
          sync_err_d = 1'b1;
          // The frame in progress is tainted unless the drop falls exactly on its start.
          frame_ok_d = vs_lead;
        end else if (vs_lead) begin
          frame_ok_d = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_p0_q     <= 1'b0;
      hs_p1_q     <= 1'b0;
      vs_p0_q     <= 1'b0;
      vs_p1_q     <= 1'b0;
      de_p0_q     <= 1'b0;
      de_p1_q     <= 1'b0;
      h_cnt_q     <= 11'd0;
      h_started_q <= 1'b0;
      h_meas_q    <= 11'd0;
      v_cnt_q     <= 11'd0;
      v_meas_q    <= 11'd0;
      de_cnt_q    <= 11'd0;
      pix_x_q     <= 10'd0;
      pix_y_q     <= 10'd0;
      row_first_q <= 1'b0;
      state_q     <= SEARCH;
      good_q      <= 8'd0;
      frame_ok_q  <= 1'b0;
      locked_q    <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      hs_p0_q     <= hs_p0_d;
      hs_p1_q     <= hs_p1_d;
      vs_p0_q     <= vs_p0_d;
      vs_p1_q     <= vs_p1_d;
      de_p0_q     <= de_p0_d;
      de_p1_q     <= de_p1_d;
      h_cnt_q     <= h_cnt_d;
      h_started_q <= h_started_d;
      h_meas_q    <= h_meas_d;
      v_cnt_q     <= v_cnt_d;
      v_meas_q    <= v_meas_d;
      de_cnt_q    <= de_cnt_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      row_first_q <= row_first_d;
      state_q     <= state_d;
      good_q      <= good_d;
      frame_ok_q  <= frame_ok_d;
      locked_q    <= locked_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign pix_valid    = de_p0_q;
  assign pix_x        = pix_x_q;
  assign pix_y        = pix_y_q;
  assign h_total_meas = h_meas_q;
  assign v_total_meas = v_meas_q;
  assign locked       = locked_q;
  assign sync_err     = sync_err_q;

endmodule
